// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-control constants, stall-vector indices and ID/EX payload layout for the 5-stage core.
package pipe_stage_reg_pkg;

  localparam logic Stop       = 1'b1;
  localparam logic NoStop     = 1'b0;
  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_IF  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;
  localparam int unsigned STG_WB  = 5;

  localparam int unsigned ALUOP_W   = 8;
  localparam int unsigned ALUSEL_W  = 3;
  localparam int unsigned REG_W     = 32;
  localparam int unsigned REGADDR_W = 5;
  localparam int unsigned INST_W    = 32;

  localparam logic [ALUOP_W-1:0]  EXE_NOP_OP  = '0;
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP = '0;

  typedef struct packed {
    logic [ALUOP_W-1:0]   aluop;
    logic [ALUSEL_W-1:0]  alusel;
    logic [REG_W-1:0]     reg1;
    logic [REG_W-1:0]     reg2;
    logic [REGADDR_W-1:0] wd;
    logic                 wreg;
    logic [REG_W-1:0]     link_addr;
    logic                 is_in_delayslot;
    logic [INST_W-1:0]    inst;
  } id_ex_payload_t;

  localparam int unsigned ID_EX_W = $bits(id_ex_payload_t);

  localparam id_ex_payload_t ID_EX_NOP = '{
    aluop:           EXE_NOP_OP,
    alusel:          EXE_RES_NOP,
    reg1:            '0,
    reg2:            '0,
    wd:              '0,
    wreg:            1'b0,
    link_addr:       '0,
    is_in_delayslot: 1'b0,
    inst:            '0
  };

  typedef enum logic [1:0] {
    OP_LOAD,
    OP_BUBBLE,
    OP_HOLD,
    OP_FLUSH
  } stage_op_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; stops at MAX instead of wrapping.
module sat_counter #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: payload + valid under the global stall vector, with flush,
// saturating bubble/hold counters and a sticky hold-timeout flag.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W   = 64,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter int unsigned       STALL_W  = 6,
  parameter int unsigned       STAGE    = 2,
  parameter int unsigned       CNT_W    = 16,
  parameter int unsigned       HOLD_MAX = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   hold_cnt,
  output logic               hold_timeout
);

  if ((STAGE + 1 >= STALL_W) || (DATA_W < 1)) begin : g_bad_param
    $error("pipe_stage_reg: STAGE+1 must be < STALL_W and DATA_W >= 1");
  end

  // Run counter only needs to reach HOLD_MAX+1, so size it from HOLD_MAX.
  localparam int unsigned     RUN_W   = $clog2(HOLD_MAX + 2);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(HOLD_MAX);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(HOLD_MAX + 1);

  logic             up;
  logic             dn;
  stage_op_e        op;
  logic [RUN_W-1:0] run_cnt;

  assign up = stall[STAGE];
  assign dn = stall[STAGE+1];

  // Illegal !up & dn falls through to LOAD.
  always_comb begin
    op = OP_LOAD;
    if (flush) begin
      op = OP_FLUSH;
    end else if (up == Stop && dn == NoStop) begin
      op = OP_BUBBLE;
    end else if (up == Stop && dn == Stop) begin
      op = OP_HOLD;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (op == OP_BUBBLE),
    .clr   (1'b0),
    .count (bubble_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (op == OP_HOLD),
    .clr   (1'b0),
    .count (hold_cnt)
  );

  sat_counter #(.WIDTH(RUN_W), .MAX(RUN_SAT)) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (op == OP_HOLD),
    .clr   (op != OP_HOLD),
    .count (run_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      out_valid    <= 1'b0;
      out_data     <= NOP_DATA;
      hold_timeout <= 1'b0;
    end else begin
      unique case (op)
        OP_FLUSH: begin
          out_valid    <= 1'b0;
          out_data     <= NOP_DATA;
          hold_timeout <= 1'b0;
        end
        OP_BUBBLE: begin
          out_valid <= 1'b0;
          out_data  <= NOP_DATA;
        end
        OP_HOLD: begin
          // Sets on the edge where the run count moves past HOLD_MAX.
          if ((HOLD_MAX > 0) && (run_cnt >= RUN_LIM)) begin
            hold_timeout <= 1'b1;
          end
        end
        default: begin
          out_valid <= in_valid;
          out_data  <= in_valid ? in_data : NOP_DATA;
        end
      endcase
    end
  end

  a_illegal_stall: assert property (@(posedge clk) disable iff (rst)
    !(up == NoStop && dn == Stop));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed-vector bench for pipe_stage_reg (DATA_W=16, STAGE=2, CNT_W=3, HOLD_MAX=4).
module tb_pipe_stage_reg;

  localparam logic [15:0] NOP = 16'h5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  bubble_cnt;
  logic [2:0]  hold_cnt;
  logic        hold_timeout;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  pipe_stage_reg #(
    .DATA_W   (16),
    .NOP_DATA (NOP),
    .STALL_W  (6),
    .STAGE    (2),
    .CNT_W    (3),
    .HOLD_MAX (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .bubble_cnt   (bubble_cnt),
    .hold_cnt     (hold_cnt),
    .hold_timeout (hold_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 6'b000000; flush = 1'b0; in_valid = 1'b1; in_data = 16'hDEAD;
    step(2);
    check("rst_valid",   32'(out_valid),    32'd0);
    check("rst_data",    32'(out_data),     32'(NOP));
    check("rst_bubble",  32'(bubble_cnt),   32'd0);
    check("rst_hold",    32'(hold_cnt),     32'd0);
    check("rst_timeout", 32'(hold_timeout), 32'd0);

    rst = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
    step(1);
    check("load_valid", 32'(out_valid), 32'd1);
    check("load_data",  32'(out_data),  32'h1234);

    in_valid = 1'b0; in_data = 16'h7777;
    step(1);
    check("load_inv_valid", 32'(out_valid), 32'd0);
    check("load_inv_data",  32'(out_data),  32'(NOP));

    stall = 6'b000100; in_valid = 1'b1; in_data = 16'h4444;
    step(1);
    check("bubble_valid", 32'(out_valid),  32'd0);
    check("bubble_data",  32'(out_data),   32'(NOP));
    check("bubble_cnt1",  32'(bubble_cnt), 32'd1);

    stall = 6'b000000; in_data = 16'hABCD;
    step(1);
    stall = 6'b001100; in_data = 16'hFFFF;
    step(3);
    check("hold_data",    32'(out_data),     32'hABCD);
    check("hold_valid",   32'(out_valid),    32'd1);
    check("hold_cnt3",    32'(hold_cnt),     32'd3);
    check("hold_no_to",   32'(hold_timeout), 32'd0);
    check("hold_bubble",  32'(bubble_cnt),   32'd1);

    stall = 6'b000000; in_data = 16'h1111;
    step(1);
    check("reload_data", 32'(out_data), 32'h1111);
    stall = 6'b111100; in_data = 16'h2222;
    step(4);
    check("run4_no_to", 32'(hold_timeout), 32'd0);
    step(1);
    check("run5_to", 32'(hold_timeout), 32'd1);
    step(1);
    check("run6_to",    32'(hold_timeout), 32'd1);
    check("hold_sat",   32'(hold_cnt),     32'd7);
    check("run6_data",  32'(out_data),     32'h1111);

    stall = 6'b000000; in_data = 16'h3333;
    step(1);
    check("to_sticky", 32'(hold_timeout), 32'd1);
    check("post_data", 32'(out_data),     32'h3333);

    stall = 6'b001100; flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("flush_valid",   32'(out_valid),    32'd0);
    check("flush_data",    32'(out_data),     32'(NOP));
    check("flush_to",      32'(hold_timeout), 32'd0);
    check("flush_holdcnt", 32'(hold_cnt),     32'd7);
    check("flush_bubble",  32'(bubble_cnt),   32'd1);

    rst = 1'b1;
    step(1);
    rst = 1'b0; stall = 6'b000100;
    check("rst2_hold", 32'(hold_cnt), 32'd0);
    step(1);
    check("rst_stall_bubble", 32'(bubble_cnt), 32'd1);
    stall = 6'b000111;
    step(6);
    check("bubble7", 32'(bubble_cnt), 32'd7);
    step(2);
    check("bubble_sat", 32'(bubble_cnt), 32'd7);
    check("bubble_sat_valid", 32'(out_valid), 32'd0);

    stall = 6'b000000; in_valid = 1'b1; in_data = 16'h6666; flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("flush_load_valid", 32'(out_valid), 32'd0);
    check("flush_load_data",  32'(out_data),  32'(NOP));
    step(1);
    check("after_flush_data", 32'(out_data), 32'h6666);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
